// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel counters, visible flag,
// delayed active-low syncs and line/frame markers.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // 11-bit bounds so a limit of exactly 1024 still compares correctly
  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
        SYNC_DELAY > 4 || SYNC_DELAY < 0) begin : g_bad_cfg
      $fatal(1, "vga_timing_gen: unsupported parameters");
    end
  endgenerate

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [7:0]  r_fc;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_hs_raw;
  logic        w_vs_raw;

  assign w_x = {1'b0, r_x};
  assign w_y = {1'b0, r_y};

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_fc <= '0;
    end else if (w_x == H_MAX) begin
      r_x <= '0;
      if (w_y == V_MAX) begin
        r_y  <= '0;
        r_fc <= r_fc + 8'd1;
      end else begin
        r_y <= r_y + 10'd1;
      end
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  assign w_hs_raw = !((w_x >= HS_BEG) && (w_x < HS_END));
  assign w_vs_raw = !((w_y >= VS_BEG) && (w_y < VS_END));

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hs = w_hs_raw;
      assign vs = w_vs_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] r_hs_d;
      logic [SYNC_DELAY-1:0] r_vs_d;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_hs_d <= '1;
          r_vs_d <= '1;
        end else begin
          r_hs_d[0] <= w_hs_raw;
          r_vs_d[0] <= w_vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            r_hs_d[i] <= r_hs_d[i-1];
            r_vs_d[i] <= r_vs_d[i-1];
          end
        end
      end

      assign hs = r_hs_d[SYNC_DELAY-1];
      assign vs = r_vs_d[SYNC_DELAY-1];
    end
  endgenerate

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign frame_cnt   = r_fc;
  assign blank       = (w_x < H_VIS) && (w_y < V_VIS);
  assign line_start  = (r_x == 10'd0);
  assign frame_start = (r_x == 10'd0) && (r_y == 10'd0);

endmodule
